// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 4-bit ALUop encodings (unchanged from the single-cycle datapath ALU)
//   - control state enum (IDLE/BUSY/DONE)
//   - is_multicycle(): true for opcodes handled by the iterative mul/div unit
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) ||
           (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative unsigned multiply / divide, one bit per cycle.
//   clk, rst : clock, synchronous active-high reset (aborts any operation)
//   start    : load operands and begin (ignored while rst is high)
//   op       : OP_MUL / OP_MULHU / OP_DIVU / OP_REMU
//   a, b     : operands (multiplicand/multiplier or dividend/divisor)
//   done     : combinational pulse during the last iteration cycle
//   result   : value that the last iteration produces; valid while done=1
//
// Both algorithms share one {hi, lo} register pair:
//   mul : hi = partial product high half, lo = multiplier shifting out /
//         product low half shifting in; opd = multiplicand.
//   div : hi = partial remainder, lo = dividend shifting out / quotient
//         shifting in; opd = divisor. A zero divisor needs no special case:
//         every trial subtraction succeeds (quotient all ones) and the
//         remainder accumulates the dividend bits unchanged.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             want_hi;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opd;

  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic             fits;

  always_comb begin
    hi_nxt  = hi;
    lo_nxt  = lo;
    mul_sum = '0;
    shifted = '0;
    fits    = 1'b0;
    if (is_div) begin
      // Restoring step: bring in the next dividend bit, subtract if it fits.
      // The true difference is below opd, so a WIDTH-bit subtract is exact.
      shifted = {hi, lo[WIDTH-1]};
      fits    = (shifted >= {1'b0, opd});
      if (fits) begin
        hi_nxt = shifted[WIDTH-1:0] - opd;
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift-add step: conditionally add, then shift {carry, hi, lo} right.
      mul_sum = lo[0] ? ({1'b0, hi} + {1'b0, opd}) : {1'b0, hi};
      hi_nxt  = mul_sum[WIDTH:1];
      lo_nxt  = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // count reaches all ones on the WIDTH-th iteration
  assign done   = busy && (&count);
  assign result = want_hi ? hi_nxt : lo_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      count   <= '0;
      is_div  <= 1'b0;
      want_hi <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      opd     <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      count   <= '0;
      is_div  <= (op == OP_DIVU) || (op == OP_REMU);
      want_hi <= (op == OP_MULHU) || (op == OP_REMU);
      hi      <= '0;
      if ((op == OP_DIVU) || (op == OP_REMU)) begin
        lo  <= a;
        opd <= b;
      end else begin
        lo  <= b;
        opd <= a;
      end
    end else if (busy) begin
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      count <= count + 1'b1;
      if (&count) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered EX-stage ALU.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid      : operation request
//   in_ready      : request accepted when high (IDLE only)
//   alu_op        : 4-bit opcode (see alu_pkg)
//   ina, inb      : operands; shift amount is inb[$clog2(WIDTH)-1:0]
//   out_valid     : result valid (DONE)
//   out_ready     : consumer takes the result
//   out/zero/err  : registered result, result==0, illegal-opcode flag
// Single-cycle and illegal ops complete at the acceptance edge; mul/div
// (ENABLE_MULDIV=1) iterate WIDTH cycles in alu_muldiv_iter.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter bit          ENABLE_MULDIV = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             err
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t           state;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             illegal;
  logic             go_multi;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  assign shamt    = inb[SHW-1:0];
  assign go_multi = ENABLE_MULDIV && is_multicycle(alu_op);

  // Single-cycle op mux; mul/div opcodes land in default and are flagged
  // illegal, which is only used when the iterative unit is not built.
  always_comb begin
    alu_res = '0;
    illegal = 1'b0;
    case (alu_op)
      OP_ADD:  alu_res = ina + inb;
      OP_SUB:  alu_res = ina - inb;
      OP_AND:  alu_res = ina & inb;
      OP_OR:   alu_res = ina | inb;
      OP_XOR:  alu_res = ina ^ inb;
      OP_SLL:  alu_res = ina << shamt;
      OP_SRL:  alu_res = ina >> shamt;
      OP_SRA:  alu_res = $signed(ina) >>> shamt;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (ina < inb)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(ina) < $signed(inb))};
      default: illegal = 1'b1;
    endcase
  end

  generate
    if (ENABLE_MULDIV) begin : g_muldiv
      logic md_start;
      assign md_start = (state == IDLE) && in_valid && go_multi;

      alu_muldiv_iter #(
        .WIDTH(WIDTH)
      ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (alu_op),
        .a      (ina),
        .b      (inb),
        .done   (md_done),
        .result (md_result)
      );
    end else begin : g_no_muldiv
      assign md_done   = 1'b0;
      assign md_result = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out       <= '0;
      zero      <= 1'b1;
      err       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (go_multi) begin
              state <= BUSY;
            end else begin
              out       <= alu_res;
              zero      <= (alu_res == '0);
              err       <= illegal;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          if (md_done) begin
            out       <= md_result;
            zero      <= (md_result == '0);
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32, mul/div on).
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] ina;
  logic [31:0] inb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        zero;
  logic        err;

  int checks = 0;
  int errors = 0;

  alu_seq #(
    .WIDTH        (32),
    .ENABLE_MULDIV(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .ina      (ina),
    .inb      (inb),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .zero     (zero),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request (in IDLE, out_ready=1), wait for out_valid, check the
  // result and latency, then let it retire and check the return to IDLE.
  task automatic op_test(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_out, input logic exp_err,
                         input int exp_lat);
    int   lat;
    logic ready_seen;
    alu_op   = op;
    ina      = a;
    inb      = b;
    in_valid = 1'b1;
    step();
    // scramble inputs: only the acceptance edge may matter
    in_valid   = 1'b0;
    alu_op     = OP_XOR;
    ina        = 32'hDEAD_BEEF;
    inb        = 32'h1234_5678;
    lat        = 1;
    ready_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_seen = 1'b1;
      step();
      lat++;
    end
    check({tag, ".out"}, out, exp_out);
    check({tag, ".zero"}, zero, exp_out == 32'h0);
    check({tag, ".err"}, err, exp_err);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".in_ready_busy"}, ready_seen, 1'b0);
    step();
    check({tag, ".retire_valid"}, out_valid, 1'b0);
    check({tag, ".retire_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b1;
    alu_op    = OP_ADD;
    ina       = 32'd1;
    inb       = 32'd2;
    out_ready = 1'b1;

    // reset held 2 cycles with a pending add
    step();
    check("rst1.out_valid", out_valid, 1'b0);
    step();
    check("rst2.out_valid", out_valid, 1'b0);
    check("rst.out", out, 32'h0);
    check("rst.zero", zero, 1'b1);
    check("rst.err", err, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst.in_ready", in_ready, 1'b1);
    step();
    check("post_rst.out_valid", out_valid, 1'b0);
    check("post_rst.in_ready", in_ready, 1'b1);

    // single-cycle ops
    op_test("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'h1,        32'h0,         1'b0, 1);
    op_test("sub",      OP_SUB,  32'd10,        32'd3,        32'd7,         1'b0, 1);
    op_test("and",      OP_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1);
    op_test("or",       OP_OR,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1);
    op_test("xor",      OP_XOR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1);
    op_test("sll",      OP_SLL,  32'h1,         32'h0000_003F, 32'h8000_0000, 1'b0, 1);
    op_test("srl",      OP_SRL,  32'h8000_0000, 32'd4,        32'h0800_0000, 1'b0, 1);
    op_test("sra",      OP_SRA,  32'h8000_0000, 32'd4,        32'hF800_0000, 1'b0, 1);
    op_test("slt",      OP_SLT,  32'hFFFF_FFFF, 32'h1,        32'h1,         1'b0, 1);
    op_test("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h1,        32'h0,         1'b0, 1);
    op_test("illegal",  4'b1111, 32'h1234_5678, 32'h1,        32'h0,         1'b1, 1);

    // multiply / divide
    op_test("mul",    OP_MUL,   32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0, 33);
    op_test("mulhu",  OP_MULHU, 32'h0001_0001, 32'h0001_0001, 32'h0000_0001, 1'b0, 33);
    op_test("mulhu2", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    op_test("divu",   OP_DIVU,  32'd100,       32'd7,        32'd14,        1'b0, 33);
    op_test("remu",   OP_REMU,  32'd100,       32'd7,        32'd2,         1'b0, 33);
    op_test("divu0",  OP_DIVU,  32'd5,         32'd0,        32'hFFFF_FFFF, 1'b0, 33);
    op_test("remu0",  OP_REMU,  32'd5,         32'd0,        32'd5,         1'b0, 33);

    // backpressure: sub 5-7 held in DONE for 10 cycles, new request ignored
    out_ready = 1'b0;
    alu_op    = OP_SUB;
    ina       = 32'd5;
    inb       = 32'd7;
    in_valid  = 1'b1;
    step();
    alu_op = OP_ADD;
    ina    = 32'd1;
    inb    = 32'd1;
    check("bp.out_valid0", out_valid, 1'b1);
    check("bp.out0", out, 32'hFFFF_FFFE);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp.out", out, 32'hFFFF_FFFE);
      check("bp.out_valid", out_valid, 1'b1);
      check("bp.in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp.release_valid", out_valid, 1'b0);
    check("bp.release_ready", in_ready, 1'b1);
    check("bp.hold_out", out, 32'hFFFF_FFFE);

    // no overlap: in_valid held through DONE with out_ready=1
    alu_op   = OP_ADD;
    ina      = 32'd1;
    inb      = 32'd1;
    in_valid = 1'b1;
    step();
    check("ovl.first_out", out, 32'd2);
    alu_op = OP_ADD;
    ina    = 32'd3;
    inb    = 32'd3;
    step();
    check("ovl.done_valid", out_valid, 1'b0);
    check("ovl.done_out", out, 32'd2);
    check("ovl.done_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("ovl.second_valid", out_valid, 1'b1);
    check("ovl.second_out", out, 32'd6);
    step();

    // reset in the middle of a divide
    alu_op   = OP_DIVU;
    ina      = 32'd100;
    inb      = 32'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort.out_valid", out_valid, 1'b0);
    check("abort.in_ready", in_ready, 1'b1);
    check("abort.out", out, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("abort.no_result", seen, 1'b0);
    op_test("after_abort_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor of the single-cycle datapath ALU.
- Keeps the existing 4-bit ALUop encoding for all existing operations.
- Registers every result, fixes signed/unsigned compare semantics, and adds iterative multiply/divide.
- Sits in the EX stage. The pipeline stalls on in_ready/out_valid instead of assuming single-cycle completion.

Parameters:
- WIDTH, 32, operand/result width in bits (power of 2, ≥8).
- ENABLE_MULDIV, 1, when 0 the mul/div opcodes are illegal and the iterative unit is not built.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept; high only in IDLE.
- alu_op  input  4  opcode.
- ina  input  WIDTH  operand A.
- inb  input  WIDTH  operand B (shift amount = inb[$clog2(WIDTH)-1:0]).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  registered result.
- zero  output  1  out == 0, registered with out.
- err  output  1  illegal opcode flag, registered with out.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; out=0, zero=1, err=0, out_valid=0.
  - Any in-flight operation is aborted and its result is never presented.
- Opcodes, single-cycle:
  - 0010 add, 0110 sub, 0000 and, 0001 or, 0011 xor.
  - 0100 sll, 0101 srl, 1001 sra (arithmetic, sign of ina).
  - 0111 sltu (unsigned ina<inb → 1 else 0).
  - 1000 slt (signed ina<inb).
- Opcodes, multi-cycle (ENABLE_MULDIV=1):
  - 1010 mul (low WIDTH of product), 1011 mulhu (high WIDTH, unsigned).
  - 1100 divu, 1101 remu (unsigned).
- Any other opcode: out=0, zero=1, err=1, single-cycle latency.
- Arithmetic: add/sub wrap modulo 2^WIDTH; no carry/overflow outputs.
- Divide by zero (no err):
  - divu → all ones.
  - remu → ina.
- State machine:
  - IDLE: in_ready=1.
    - Single-cycle op or illegal op accepted (in_valid&in_ready) → result registered at that edge, go to DONE.
    - Mul/div op accepted → load operands, count=0, go to BUSY.
  - BUSY: in_ready=0, out_valid=0.
    - Mul: shift-add, 1 bit per cycle.
    - Div: restoring shift-subtract, 1 bit per cycle.
    - After WIDTH iterations, register the result at that edge and go to DONE.
  - DONE: out_valid=1; out/zero/err held stable.
    - out_ready=1 → IDLE at next edge; out_valid drops.
    - out_ready=0 → stay in DONE.
- Latency, acceptance edge to first out_valid cycle:
  - Single-cycle/illegal ops: 1 cycle.
  - Mul/div: WIDTH+1 cycles (33 at WIDTH=32).
- No overlap: a new request is not accepted while in DONE, even if out_ready=1 in that cycle. Throughput is one op per 2 cycles at best.
- Inputs ina/inb/alu_op are sampled only on the acceptance edge; later changes have no effect.
- out/zero/err keep their last value in IDLE and BUSY; only out_valid qualifies them.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants (OP_ADD=4'b0010, OP_SUB=4'b0110, OP_AND=4'b0000, OP_OR=4'b0001, OP_XOR=4'b0011, OP_SRL=4'b0101, OP_SLL=4'b0100, OP_SRA=4'b1001, OP_SLTU=4'b0111, OP_SLT=4'b1000, OP_MUL=4'b1010, OP_MULHU=4'b1011, OP_DIVU=4'b1100, OP_REMU=4'b1101);
  - the state enum (IDLE/BUSY/DONE);
  - a function is_multicycle(op).
- One sub-module: alu_muldiv_iter.
  - Interface: start, op, a, b → done pulse, result.
  - Holds the counter and the shift registers.
  - Instantiated only under ENABLE_MULDIV.
- The combinational op mux stays in alu_seq.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, op=add → out_valid=0, out=0, zero=1, err=0, in_ready=1 after rst drops.
- Single-cycle ops (WIDTH=32):
  - add 0xFFFFFFFF+1 → out=0, zero=1, out_valid one cycle after acceptance.
  - sra 0x80000000 by 4 → 0xF8000000.
  - slt 0xFFFFFFFF<1 → 1.
  - sltu 0xFFFFFFFF<1 → 0.
  - Illegal op 4'b1111 → out=0, err=1.
- Multiply: mul 0x00010001×0x00010001 → 0x00020001; mulhu of the same operands → 0x00000001. out_valid exactly 33 cycles after acceptance; in_ready=0 throughout.
- Divide: divu 100/7 → 14, remu → 2. divu x/0 with x=5 → 0xFFFFFFFF, remu 5/0 → 5, err=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after sub 5-7 → out stays 0xFFFFFFFE, out_valid stays 1, in_ready=0, new in_valid ignored.
  - Release out_ready → IDLE next cycle.
- Reset mid-operation: assert rst at cycle 10 of a divu → no out_valid for the aborted op; next add 2+3 returns 5 with latency 1.
